// File: rtl/decoder_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_arb_pkg
//  Purpose  : Shared types, sizes and the round-robin search helper for the
//             decoder_rr_arbiter block.
//  Contents : N_REQ / IDX_W sizes, arb_state_t FSM encoding,
//             rr_pick_t result record, rr_pick() search function.
//  Revision : 1.0  initial release
// ============================================================================
package decoder_arb_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } rr_pick_t;

   // First set bit of req, searching ptr, ptr+1, ... with wrap from 7 to 0.
   // The loop walks the offsets from farthest to nearest so that the nearest
   // hit is the last one written and therefore wins.
   function automatic rr_pick_t rr_pick(input logic [N_REQ-1:0] req,
                                        input logic [IDX_W-1:0] ptr);
      rr_pick_t         r;
      logic [IDX_W-1:0] k;
      r.found = 1'b0;
      r.idx   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         k = ptr + IDX_W'(i);
         if (req[k]) begin
            r.found = 1'b1;
            r.idx   = k;
         end
      end
      return r;
   endfunction

endpackage : decoder_arb_pkg
`default_nettype wire

// File: rtl/decoder_3X8.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_3X8
//  Purpose  : Plain 3-to-8 one-hot decoder.
//  Ports    : in  [2:0] binary index
//             y   [7:0] one-hot output, y[in] = 1
//  Revision : 1.0  initial release
// ============================================================================
module decoder_3X8 (
   input  logic [2:0] in,
   output logic [7:0] y
);

   always_comb begin
      y = 8'h01 << in;
   end

endmodule : decoder_3X8
`default_nettype wire

// File: rtl/decoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_rr_arbiter
//  Purpose  : Round-robin arbiter sharing one resource among eight
//             requesters. A registered grant index drives a decoder_3X8 to
//             form the one-hot grant. A grant is held until the grantee drops
//             its request or MAX_HOLD cycles have elapsed; every release is
//             followed by one idle turnaround cycle.
//  Params   : MAX_HOLD   max consecutive grant cycles, legal 2..256
//  Ports    : clk          clock, rising edge
//             rst_n        asynchronous active-low reset
//             i_req  [7:0] level-sensitive request vector
//             i_en         arbitration enable (blocks new grants only)
//             o_gnt  [7:0] one-hot grant, zero when no grant is active
//             o_gnt_idx[2:0] index of current / most recent grantee
//             o_gnt_valid  grant active
//             o_busy       FSM in GRANT, same as o_gnt_valid
//  Revision : 1.0  initial release
// ============================================================================
module decoder_rr_arbiter
   import decoder_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] i_req,
   input  logic             i_en,
   output logic [N_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0] o_gnt_idx,
   output logic             o_gnt_valid,
   output logic             o_busy
);

   localparam int                 CNT_W       = $clog2(MAX_HOLD);
   localparam logic [CNT_W-1:0]   c_hold_last = CNT_W'(MAX_HOLD - 1);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic [IDX_W-1:0]  r_ptr;
   logic [IDX_W-1:0]  w_ptr_nxt;
   logic [IDX_W-1:0]  r_gnt_idx;
   logic [IDX_W-1:0]  w_gnt_idx_nxt;
   logic [CNT_W-1:0]  r_hold_cnt;
   logic [CNT_W-1:0]  w_hold_cnt_nxt;
   rr_pick_t          w_pick;
   logic              w_valid;
   logic [N_REQ-1:0]  w_dec;

   always_comb begin
      w_pick = rr_pick(i_req, r_ptr);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ARB_IDLE;
         r_ptr      <= '0;
         r_gnt_idx  <= '0;
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_ptr      <= w_ptr_nxt;
         r_gnt_idx  <= w_gnt_idx_nxt;
         r_hold_cnt <= w_hold_cnt_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt    = r_state;
      w_ptr_nxt      = r_ptr;
      w_gnt_idx_nxt  = r_gnt_idx;
      w_hold_cnt_nxt = r_hold_cnt;
      case (r_state)
         ARB_IDLE: begin
            if (i_en && w_pick.found) begin
               w_state_nxt    = ARB_GRANT;
               w_gnt_idx_nxt  = w_pick.idx;
               w_hold_cnt_nxt = '0;
            end
         end
         ARB_GRANT: begin
            w_hold_cnt_nxt = r_hold_cnt + 1'b1;
            // Voluntary and forced release collapse into one release, so the
            // pointer moves exactly one place past the grantee either way.
            if (!i_req[r_gnt_idx] || (r_hold_cnt == c_hold_last)) begin
               w_state_nxt = ARB_IDLE;
               w_ptr_nxt   = r_gnt_idx + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ARB_IDLE;
         end
      endcase
   end

   assign w_valid = (r_state == ARB_GRANT);

   decoder_3X8 u_dec (
      .in (r_gnt_idx),
      .y  (w_dec)
   );

   // The decoder always drives one hot bit; gating keeps gnt at zero in IDLE.
   assign o_gnt       = w_dec & {N_REQ{w_valid}};
   assign o_gnt_idx   = r_gnt_idx;
   assign o_gnt_valid = w_valid;
   assign o_busy      = w_valid;

endmodule : decoder_rr_arbiter
`default_nettype wire

// File: tb/tb_decoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_rr_arbiter
//  Purpose  : Directed self-checking bench for decoder_rr_arbiter with
//             MAX_HOLD = 4. Inputs change and outputs are sampled on the
//             falling clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decoder_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       en;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       busy;

   int n_checks;
   int n_errors;

   decoder_rr_arbiter #(.MAX_HOLD(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req       (req),
      .i_en        (en),
      .o_gnt       (gnt),
      .o_gnt_idx   (gnt_idx),
      .o_gnt_valid (gnt_valid),
      .o_busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Grant output with its companion flags in one go.
   task automatic chk_gnt(input string tag, input logic [7:0] exp);
      chk(tag, {24'h0, gnt}, {24'h0, exp});
      chk({tag, "_valid"}, {31'h0, gnt_valid}, {31'h0, (exp != 8'h00)});
      chk({tag, "_busy"}, {31'h0, busy}, {31'h0, (exp != 8'h00)});
   endtask

   logic [7:0] e;

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      req   = 8'hFF;
      en    = 1'b1;

      // Reset state
      step;
      step;
      chk_gnt("rst_gnt", 8'h00);
      chk("rst_idx", {29'h0, gnt_idx}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk_gnt("rst_rel_noedge", 8'h00);

      // Rotation 0..7 then wrap to 0: 4 grant cycles + 1 idle cycle each
      for (int g = 0; g < 9; g++) begin
         e = 8'h01 << (g % 8);
         for (int c = 0; c < 4; c++) begin
            step;
            chk_gnt("rot_gnt", e);
            if (c == 0) chk("rot_idx", {29'h0, gnt_idx}, 32'(g % 8));
         end
         step;
         chk_gnt("rot_gap", 8'h00);
      end

      // Voluntary release (ptr = 1): 0x24 -> grant 2, then 5
      req = 8'h24;
      step; chk_gnt("vol_g2a", 8'h04);
      step; chk_gnt("vol_g2b", 8'h04);
      step; chk_gnt("vol_g2c", 8'h04);
      req = 8'h20;
      step; chk_gnt("vol_gap", 8'h00);
      step; chk_gnt("vol_g5", 8'h20);
      chk("vol_idx5", {29'h0, gnt_idx}, 32'd5);
      req = 8'h00;
      step; chk_gnt("vol_rel", 8'h00);

      // Enable gating (ptr = 6): grant 3 survives en low
      req = 8'h08;
      step; chk_gnt("en_g3a", 8'h08);
      en = 1'b0;
      step; chk_gnt("en_g3b", 8'h08);
      req = 8'h89;
      step; chk_gnt("en_g3c", 8'h08);
      req = 8'h81;
      step; chk_gnt("en_blk1", 8'h00);
      step; chk_gnt("en_blk2", 8'h00);
      step; chk_gnt("en_blk3", 8'h00);
      chk("en_idx_hold", {29'h0, gnt_idx}, 32'd3);
      en = 1'b1;
      step; chk_gnt("en_g7", 8'h80);
      chk("en_idx7", {29'h0, gnt_idx}, 32'd7);

      // Async reset mid-grant: release 7 (ptr -> 0), grant 4
      req = 8'h10;
      step; chk_gnt("ar_gap", 8'h00);
      step; chk_gnt("ar_g4", 8'h10);
      req = 8'h30;
      #2 rst_n = 1'b0;
      #1;
      chk_gnt("ar_drop", 8'h00);
      chk("ar_idx", {29'h0, gnt_idx}, 32'd0);
      step; chk_gnt("ar_hold", 8'h00);
      rst_n = 1'b1;

      // After reset ptr = 0 -> bit 4 wins over bit 5; then hit the
      // voluntary drop and the hold limit on the same edge.
      step; chk_gnt("sim_a", 8'h10);
      chk("sim_idx4", {29'h0, gnt_idx}, 32'd4);
      step; chk_gnt("sim_b", 8'h10);
      step; chk_gnt("sim_c", 8'h10);
      step; chk_gnt("sim_d", 8'h10);
      req = 8'h21;
      step; chk_gnt("sim_gap", 8'h00);
      step; chk_gnt("sim_next", 8'h20);
      chk("sim_idx5", {29'h0, gnt_idx}, 32'd5);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_decoder_rr_arbiter
`default_nettype wire

// File: doc/decoder_rr_arbiter.md
# decoder_rr_arbiter

Round-robin arbiter that shares one 8-way resource among eight requesters. It selects a 3-bit grant index and drives the one-hot grant vector through a `decoder_3X8` instance. Each grant is held until the requester releases it or a hold limit expires. It sits between the requester blocks and the shared resource, which consumes `gnt`.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles a single grant may be held; legal range 2..256.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `req`  input  8  request vector; bit i is requester i, level-sensitive.
- `en`  input  1  arbitration enable; when low, no new grant is issued.
- `gnt`  output  8  one-hot grant, equal to `decoder_3X8(gnt_idx)` gated by `gnt_valid`.
- `gnt_idx`  output  3  index of the current or most recent grantee.
- `gnt_valid`  output  1  a grant is active.
- `busy`  output  1  high in GRANT state; identical to `gnt_valid`.

## Operation
- States: IDLE and GRANT. Reset state is IDLE.
- Internal registers:
  - `ptr` (3 bits): first index to search. Reset value 0.
  - `hold_cnt` (width clog2(MAX_HOLD)). Reset value 0.
- IDLE, when `en`=1 and `req`≠0:
  - Grant the first set bit of `req` searching `ptr`, `ptr+1`, … mod 8. The search wraps from 7 to 0.
  - Load `gnt_idx` with that index, clear `hold_cnt`, and go to GRANT.
- IDLE, when `en`=0 or `req`=0: stay in IDLE. `gnt`=0.
- GRANT: increment `hold_cnt` every cycle. Release on the first edge where either condition holds:
  - `req[gnt_idx]`=0, or
  - `hold_cnt`==MAX_HOLD-1 (forced release, even if still requesting).
- On release: `ptr` <= `gnt_idx`+1 mod 8, go to IDLE, and deassert `gnt`. A released requester therefore has lowest priority in the next arbitration.
- Changes to `req` bits other than the grantee's have no effect during GRANT.
- `en` falling during GRANT does not abort the current grant. It only blocks the next one.
- `gnt` is never multi-hot. `gnt` is 0 whenever `gnt_valid`=0.
- `gnt_idx` holds its last value through IDLE; it is meaningful only with `gnt_valid`.

## Timing
- Reset values (immediate on `rst_n` low, independent of `clk`):
  - `gnt`=8'h00, `gnt_idx`=3'b000, `gnt_valid`=0, `busy`=0, `ptr`=0, `hold_cnt`=0, state IDLE.
  - Reset mid-grant drops `gnt` immediately. No release pointer update occurs; `ptr` returns to 0.
- Request-to-grant latency: a request sampled at edge N in IDLE gives `gnt` high after edge N. Latency is 1 cycle, registered.
- Release-to-next-grant: release at edge N gives `gnt`=0 for one cycle after N. The next grant is visible after edge N+1. This mandatory one-cycle gap gives the shared resource a turnaround cycle.
- Forced release: a requester that holds `req` high continuously receives exactly MAX_HOLD cycles of `gnt`.
- Simultaneous events: when the grantee drops `req` and `hold_cnt` hits its limit on the same edge, perform one release; `ptr` updates once.
- Single requester: after a forced release it is re-granted after the one-cycle gap. It cannot starve others because `ptr` has moved past it.
- All outputs are registered. There is no combinational path from `req` to `gnt`.

## Structure
- Package `decoder_arb_pkg`:
  - `N_REQ`=8, `IDX_W`=3.
  - State enum `arb_state_t` {ARB_IDLE, ARB_GRANT}.
  - Function `rr_pick(req, ptr)` returning the index and a found flag.
- Sub-module: one instance of the existing `decoder_3X8`, with `in`=`gnt_idx` and `y` ANDed with `{8{gnt_valid}}`. This gives `gnt`.
- Pointer search and FSM live in the top module. No other sub-modules.

## Test plan
- Reset: hold `rst_n`=0 with `req`=8'hFF, then release. Expect `gnt`=8'h00 until the first edge. Then `gnt`=8'h01 and `gnt_idx`=0.
- Rotation: `req`=8'hFF held constant, MAX_HOLD=4. Expect grants in order 0,1,2,…,7,0. Each lasts 4 cycles, separated by one idle cycle. Confirm the 7→0 wrap.
- Voluntary release: `req`=8'h24 (bits 2 and 5). Grant goes to 2. Drop bit 2 after 3 cycles. Expect one idle cycle, then `gnt`=8'h20.
- Enable gating: in GRANT to index 3, drop `en`. Grant 3 persists until `req[3]` drops. Then `gnt` stays 0 with `req`=8'h81 until `en` returns. Then `gnt`=8'h80, since `ptr`=4.
- Async reset mid-grant: assert `rst_n`=0 between clock edges while `gnt`=8'h10. Expect `gnt`=8'h00 before the next edge. After reset, `ptr`=0.
- Simultaneous release: drop `req[gnt_idx]` on the same cycle `hold_cnt` reaches MAX_HOLD-1. Expect exactly one idle cycle and `ptr` advanced by one position past the grantee.
